// File: rtl/stage_feed_arbiter.sv
// Round-robin feed of two clocked requesters into one two-phase bundled-data stage.
// Optional acknowledge watchdog enabled by defining STAGE_FEED_TIMEOUT_EN.
module stage_feed_arbiter #(
  parameter int DATA_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ack_in,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   ptr_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   ack_s;
  logic [DATA_W-1:0]      data_out_r;
  logic                   valid_out_r;
  logic                   grant_id_r;
  logic                   busy_r;
  logic                   pick1_s;
  logic                   grant0_s;
  logic                   grant1_s;
  logic                   accept_s;

  assign ack_s = sync_r[SYNC_STAGES-1];

  // Arbitration: a lone requester wins, on contention the one not granted last wins.
  always_comb begin
    pick1_s  = 1'b0;
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      pick1_s = (ptr_r == 1'b0);
    end else if (req1_valid) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
    if (state_r == IDLE) begin
      grant0_s = req0_valid && !pick1_s;
      grant1_s = req1_valid && pick1_s;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign accept_s   = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Next-state logic for the request/acknowledge handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        state_nxt_s = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s == valid_out_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_ACK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, synchronizer, captured word and the two-phase request toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b1;
      sync_r      <= {SYNC_STAGES{1'b0}};
      data_out_r  <= {DATA_W{1'b0}};
      valid_out_r <= 1'b0;
      grant_id_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sync_r  <= {sync_r[SYNC_STAGES-2:0], ack_in};
      busy_r  <= (state_nxt_s != IDLE);
      if (accept_s) begin
        data_out_r <= grant1_s ? req1_data : req0_data;
        grant_id_r <= grant1_s;
        ptr_r      <= grant1_s;
      end
      // Data was registered a full cycle earlier, so the request edge follows it.
      if (state_r == SETUP) begin
        valid_out_r <= ~valid_out_r;
      end
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_out_r;
  assign grant_id  = grant_id_r;
  assign busy      = busy_r;

`ifdef STAGE_FEED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt_r;
  logic             timeout_err_r;

  // Acknowledge watchdog; the FSM keeps waiting so a late ack is still honoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r    <= {CNT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      if (state_r == SETUP) begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == WAIT_ACK) && (wait_cnt_r != TIMEOUT_C)) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end
      if ((state_r == WAIT_ACK) && (wait_cnt_r == (TIMEOUT_C - CNT_W'(1)))) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_stage_feed_arbiter.sv
// Directed self-checking bench for stage_feed_arbiter; models the stage as an ack echo 3 ns after each request toggle.
module tb_stage_feed_arbiter;

  localparam int DW = 3;
`ifdef STAGE_FEED_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ack_in;
  logic          grant_id;
  logic          busy;
  logic          timeout_err;

  int   checks;
  int   failures;
  logic exp_vo;
  logic ack_en;

  stage_feed_arbiter #(.DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .data_out(data_out), .valid_out(valid_out), .ack_in(ack_in),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stage model: echo the request phase on ack 3 ns after each toggle.
  initial begin
    forever begin
      @(valid_out);
      #3;
      if (ack_en) ack_in = valid_out;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (data_out !== 3'd0 || valid_out !== 1'b0 || grant_id !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values data=%0d vo=%b gid=%b busy=%b terr=%b required 0,0,0,0,0",
               data_out, valid_out, grant_id, busy, timeout_err);
    end
    rst = 1'b0;
    exp_vo = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1;
    req0_data  = 3'd1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready r0=%b r1=%b required 1,0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    checks++;
    if (data_out !== 3'd1 || grant_id !== 1'b0 || valid_out !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_setup data=%0d gid=%b vo=%b busy=%b required 1,0,0,1",
               data_out, grant_id, valid_out, busy);
    end
    step();
    exp_vo = ~exp_vo;
    checks++;
    if (valid_out !== exp_vo || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_toggle vo=%b busy=%b required %b,1", valid_out, busy, exp_vo);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_wait busy=%b required 1", busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      int n;
      req0_valid = 1'b1;
      req0_data  = DW'(i + 1);
      #1;
      n = 0;
      while (!req0_ready && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (n !== ((i == 0) ? 0 : 3)) begin
        failures++;
        $display("FAIL stream_latency word=%0d wait=%0d required %0d", i, n, (i == 0) ? 0 : 3);
      end
      step();
      req0_valid = 1'b0;
      checks++;
      if (data_out !== DW'(i + 1) || grant_id !== 1'b0) begin
        failures++;
        $display("FAIL stream_data word=%0d data=%0d gid=%b required %0d,0", i, data_out, grant_id, i + 1);
      end
      step();
      exp_vo = ~exp_vo;
      checks++;
      if (valid_out !== exp_vo) begin
        failures++;
        $display("FAIL stream_toggle word=%0d vo=%b required %b", i, valid_out, exp_vo);
      end
    end
  endtask

  task automatic test_wait_arb();
    int n;
    drain();
    req0_valid = 1'b1;
    req0_data  = 3'd4;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL waitarb_r0 r0=%b required 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    step();
    exp_vo = ~exp_vo;
    req1_valid = 1'b1;
    req1_data  = 3'd7;
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin
      checks++;
      if (data_out !== 3'd4) begin
        failures++;
        $display("FAIL waitarb_hold data=%0d required 4", data_out);
      end
      step();
      n++;
    end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL waitarb_latency wait=%0d required 3", n);
    end
    step();
    req1_valid = 1'b0;
    checks++;
    if (data_out !== 3'd7 || grant_id !== 1'b1) begin
      failures++;
      $display("FAIL waitarb_grant data=%0d gid=%b required 7,1", data_out, grant_id);
    end
    step();
    exp_vo = ~exp_vo;
    checks++;
    if (valid_out !== exp_vo) begin
      failures++;
      $display("FAIL waitarb_toggle vo=%b required %b", valid_out, exp_vo);
    end
  endtask

  task automatic test_rst_midflight();
    drain();
    ack_en     = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 3'd2;
    #1;
    step();
    req0_valid = 1'b0;
    step();
    exp_vo = ~exp_vo;
    step();
    checks++;
    if (busy !== 1'b1 || valid_out !== exp_vo || data_out !== 3'd2) begin
      failures++;
      $display("FAIL rst_pre busy=%b vo=%b data=%0d required 1,%b,2", busy, valid_out, data_out, exp_vo);
    end
    rst    = 1'b1;
    ack_in = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0 || data_out !== 3'd0 || grant_id !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid busy=%b vo=%b data=%0d gid=%b required 0,0,0,0",
               busy, valid_out, data_out, grant_id);
    end
    rst    = 1'b0;
    ack_en = 1'b1;
    exp_vo = 1'b0;
  endtask

  task automatic test_alternate();
    req0_valid = 1'b1;
    req0_data  = 3'd5;
    req1_valid = 1'b1;
    req1_data  = 3'd6;
    for (int k = 0; k < 4; k++) begin
      int   n;
      logic eg;
      eg = (k % 2 == 1);
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (req0_ready !== ~eg || req1_ready !== eg) begin
        failures++;
        $display("FAIL alt_ready k=%0d r0=%b r1=%b required %b,%b", k, req0_ready, req1_ready, ~eg, eg);
      end
      step();
      checks++;
      if (grant_id !== eg || data_out !== (eg ? 3'd6 : 3'd5)) begin
        failures++;
        $display("FAIL alt_grant k=%0d gid=%b data=%0d required %b,%0d", k, grant_id, data_out, eg, eg ? 6 : 5);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    drain();
    exp_vo     = valid_out;
    ack_en     = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 3'd3;
    #1;
    step();
    req0_valid = 1'b0;
    step();
    exp_vo = ~exp_vo;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 7) begin
        checks++;
        if (timeout_err !== 1'b0) begin
          failures++;
          $display("FAIL timeout_early terr=%b required 0", timeout_err);
        end
      end
      if (c >= 8) begin
        checks++;
        if (timeout_err !== TO_EN || busy !== 1'b1) begin
          failures++;
          $display("FAIL timeout_flag c=%0d terr=%b busy=%b required %b,1", c, timeout_err, busy, TO_EN);
        end
      end
    end
    ack_in = exp_vo;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== 3 || timeout_err !== TO_EN) begin
      failures++;
      $display("FAIL timeout_late_ack wait=%0d terr=%b required 3,%b", n, timeout_err, TO_EN);
    end
    ack_en = 1'b1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_vo     = 1'b0;
    ack_en     = 1'b1;
    ack_in     = 1'b0;
    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_data  = 3'd0;
    req1_valid = 1'b0;
    req1_data  = 3'd0;
    test_reset();
    test_single();
    test_stream();
    test_wait_arb();
    test_rst_midflight();
    test_alternate();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_feed_arbiter.md
# stage_feed_arbiter

Clocked round-robin arbiter that shares the input of one two-phase (transition-signalled) bundled-data pipeline stage between two synchronous requesters. It accepts a word from the granted requester over a valid/ready handshake and registers it onto the stage's data bus. One setup cycle later it toggles the stage's request, then waits for the stage's acknowledge toggle through a synchronizer. It sits on the clocked side of the clocked/async boundary, in front of the first asynchronous stage.

## Interface
- DATA_W, 3: width of each requester's data and of data_out.
- SYNC_STAGES, 2: flops in the ack_in synchronizer chain (≥2).
- TIMEOUT, 64: WAIT_ACK cycle count that raises timeout_err (only with STAGE_FEED_TIMEOUT_EN).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  DATA_W  requester 0 word; stable while req0_valid && !req0_ready.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid, req1_data, req1_ready: same for requester 1.
- data_out  out  DATA_W  bundled data to the pipeline stage (registered).
- valid_out  out  1  two-phase request to the stage; each toggle = one new word.
- ack_in  in  1  two-phase acknowledge from the stage; asynchronous to clk.
- grant_id  out  1  index of the requester whose word is on data_out.
- busy  out  1  high in SETUP and WAIT_ACK.
- timeout_err  out  1  sticky acknowledge-timeout flag.

## Operation
- States: IDLE, SETUP, WAIT_ACK.
- Reset values: state=IDLE, data_out=0, valid_out=0, grant_id=0, busy=0, timeout_err=0, last-grant pointer=1 (requester 0 wins first), synchronizer flops=0. The stage must be reset in the same window so that its ack output is 0.
- req0_ready/req1_ready are combinational. A requester's ready is high only in IDLE, only when its valid is high, and only when it wins arbitration. At most one ready is high per cycle.
- Arbitration in IDLE:
  - If exactly one valid is high, that requester wins.
  - If both are high, the requester not equal to the last-grant pointer wins.
  - The pointer updates only on acceptance.
- Acceptance (valid && ready) in IDLE: data_out <= reqN_data, grant_id <= N, pointer <= N, state <= SETUP.
- SETUP (1 cycle): valid_out <= ~valid_out, state <= WAIT_ACK. This guarantees one full clock of data setup before the request edge.
- WAIT_ACK: the synchronized ack (ack_s, last flop of the chain) is compared with valid_out. When ack_s == valid_out, state <= IDLE. data_out and grant_id hold until the next acceptance.
- A requester may not drop valid or change data before its ready; the behaviour for a violating requester is undefined.
- A synchronous rst asserted in any state forces the reset values on the next edge. Any in-flight word is abandoned, and the stage is reset alongside.

## Timing
- Acceptance at edge E0 → data_out valid after E0 → valid_out toggles at E1 → stage acks asynchronously.
- ack_s reflects the ack toggle SYNC_STAGES edges after it arrives. State returns to IDLE on the first edge where ack_s == valid_out.
- Earliest next acceptance is the IDLE cycle after that edge.
- For a zero-delay ack, one word completes every SYNC_STAGES+3 cycles (5 with the defaults).
- When valids arrive while busy, ready stays 0 and arbitration resumes in IDLE.

## Configuration
- STAGE_FEED_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT, timeout_err <= 1. The flag is sticky until rst.
  - The FSM stays in WAIT_ACK, because a late ack is still honoured.
- STAGE_FEED_TIMEOUT_EN undefined: no counter; timeout_err is tied to 0; the port is still present.

## Test plan
- After rst, assert req0_valid with data 1. Required: req0_ready high in the first IDLE cycle, data_out=1 and grant_id=0 one edge later, valid_out 0→1 one edge after that, busy=1.
- Bench toggles ack_in 3 ns after each valid_out edge. Required: return to IDLE SYNC_STAGES+1 edges after the toggle; a stream of data 1,2,3 from req0 appears on data_out in order with alternating valid_out toggles.
- Hold req0_valid and req1_valid high with data 5 and 6. Required: grants alternate 0,1,0,1 and data_out alternates 5,6,5,6.
- Assert req1_valid while in WAIT_ACK. Required: req1_ready stays 0 until IDLE, then is granted, and data_out is unchanged until acceptance.
- Assert rst while in WAIT_ACK. Required: the next edge gives state IDLE, valid_out=0, data_out=0, busy=0, and the first grant after reset goes to req0.
- With STAGE_FEED_TIMEOUT_EN and TIMEOUT=8, never toggle ack_in. Required: timeout_err rises on the 8th WAIT_ACK cycle and stays high. A later ack toggle returns the FSM to IDLE with timeout_err still 1.
